// File: rtl/tick_irq_pkg.sv
// Shared constants for the tick interrupt controller.
// Register byte offsets (PADDR[4:2] selects the word), CTRL/STATUS bit
// positions and the default pending-counter width.
package tick_irq_pkg;

  localparam int PEND_W_DEF = 8;

  localparam logic [4:0] REG_CTRL   = 5'h00;
  localparam logic [4:0] REG_STATUS = 5'h04;
  localparam logic [4:0] REG_ACK    = 5'h08;
  localparam logic [4:0] REG_TOTAL  = 5'h0C;
  localparam logic [4:0] REG_TSTAMP = 5'h10;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_CLR_BIT   = 1;
  localparam int STATUS_OVF_BIT = 31;

  // Word index of a register as seen on PADDR[4:2].
  function automatic logic [2:0] reg_idx(input logic [4:0] off);
    return off[4:2];
  endfunction

endpackage

// File: rtl/tick_pend_cnt.sv
// Saturating pending-tick counter.
// Ports:
//   i_clk, i_rst_n   clock, async active-low reset
//   i_en             increments are accepted only while set
//   i_clr            clear count and overflow (highest priority)
//   i_inc, i_dec     tick event / acknowledge; both together cancel out
//   i_ovf_clr        clear the sticky overflow flag
//   o_cnt, o_ovf     registered count and overflow flag
//   o_cnt_nxt        value the count takes at the next edge
module tick_pend_cnt
  import tick_irq_pkg::*;
#(
  parameter int PEND_W = PEND_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_clr,
  input  logic              i_inc,
  input  logic              i_dec,
  input  logic              i_ovf_clr,
  output logic [PEND_W-1:0] o_cnt,
  output logic [PEND_W-1:0] o_cnt_nxt,
  output logic              o_ovf
);

  localparam logic [PEND_W-1:0] CNT_MAX = '1;
  localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

  logic [PEND_W-1:0] r_cnt;
  logic              r_ovf;
  logic [PEND_W-1:0] w_cnt_nxt;
  logic              w_ovf_nxt;

  always_comb begin
    w_cnt_nxt = r_cnt;
    w_ovf_nxt = r_ovf;
    if (i_ovf_clr) w_ovf_nxt = 1'b0;
    if (i_clr) begin
      w_cnt_nxt = '0;
      w_ovf_nxt = 1'b0;
    end else if (i_inc && i_dec) begin
      // tick and ack in the same cycle cancel, even at 0 or at max
    end else if (i_inc) begin
      if (i_en) begin
        // a saturating tick sets ovf even if a W1C lands in the same cycle
        if (r_cnt == CNT_MAX) w_ovf_nxt = 1'b1;
        else                  w_cnt_nxt = r_cnt + CNT_ONE;
      end
    end else if (i_dec) begin
      if (r_cnt != '0) w_cnt_nxt = r_cnt - CNT_ONE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_ovf <= w_ovf_nxt;
    end
  end

  assign o_cnt     = r_cnt;
  assign o_cnt_nxt = w_cnt_nxt;
  assign o_ovf     = r_ovf;

endmodule

// File: rtl/tick_irq_ctrl.sv
// Tick-to-interrupt controller: turns the timer's single-cycle tick into a
// level interrupt, with an APB3 slave for enable, pending count, ack and stats.
// Ports:
//   pclk, nreset        clock, async active-low reset
//   tick_in             timer tick, counted on its rising edge only
//   psel/penable/pwrite/paddr/pwdata   APB3 request
//   prdata              combinational read data (0 when not selected)
//   pready / pslverr    tied 1 / 0
//   irq                 registered level interrupt
// Optional feature macro: TICK_IRQ_TIMESTAMP_EN adds a free-running cycle
// counter captured into TSTAMP (offset 0x10) on every tick; without it 0x10
// reads 0.
module tick_irq_ctrl
  import tick_irq_pkg::*;
#(
  parameter int PEND_W = PEND_W_DEF,
  parameter int ADDR_W = 5
) (
  input  logic              pclk,
  input  logic              nreset,
  input  logic              tick_in,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              irq
);

  logic              r_tick_q;
  logic              r_en;
  logic              r_irq;
  logic [31:0]       r_total;
  logic              w_tick;
  logic              w_wr;
  logic [2:0]        w_idx;
  logic              w_clr;
  logic              w_ack;
  logic              w_ovf_clr;
  logic              w_en_nxt;
  logic [PEND_W-1:0] w_pend;
  logic [PEND_W-1:0] w_pend_nxt;
  logic              w_ovf;
  logic [31:0]       w_rdata;
  logic              w_unused;

  assign w_tick    = tick_in & ~r_tick_q;
  assign w_wr      = psel & penable & pwrite;
  assign w_idx     = paddr[4:2];
  assign w_clr     = w_wr && (w_idx == reg_idx(REG_CTRL)) && pwdata[CTRL_CLR_BIT];
  assign w_ack     = w_wr && (w_idx == reg_idx(REG_ACK));
  assign w_ovf_clr = w_wr && (w_idx == reg_idx(REG_STATUS)) && pwdata[STATUS_OVF_BIT];
  assign w_en_nxt  = (w_wr && (w_idx == reg_idx(REG_CTRL))) ? pwdata[CTRL_EN_BIT] : r_en;

  tick_pend_cnt #(.PEND_W(PEND_W)) u_pend (
    .i_clk     (pclk),
    .i_rst_n   (nreset),
    .i_en      (r_en),
    .i_clr     (w_clr),
    .i_inc     (w_tick),
    .i_dec     (w_ack),
    .i_ovf_clr (w_ovf_clr),
    .o_cnt     (w_pend),
    .o_cnt_nxt (w_pend_nxt),
    .o_ovf     (w_ovf)
  );

  always_ff @(posedge pclk or negedge nreset) begin
    if (!nreset) begin
      r_tick_q <= 1'b0;
      r_en     <= 1'b0;
      r_irq    <= 1'b0;
      r_total  <= '0;
    end else begin
      r_tick_q <= tick_in;
      r_en     <= w_en_nxt;
      // irq follows next-state values so it rises with the pend that causes it
      r_irq    <= w_en_nxt & (w_pend_nxt != '0);
      if (w_tick) r_total <= r_total + 32'd1;
    end
  end

`ifdef TICK_IRQ_TIMESTAMP_EN
  logic [31:0] r_cyc;
  logic [31:0] r_tstamp;

  always_ff @(posedge pclk or negedge nreset) begin
    if (!nreset) begin
      r_cyc    <= '0;
      r_tstamp <= '0;
    end else begin
      r_cyc <= r_cyc + 32'd1;
      if (w_tick) r_tstamp <= r_cyc;
    end
  end
`endif

  always_comb begin
    w_rdata = '0;
    if (psel) begin
      case (w_idx)
        reg_idx(REG_CTRL):   w_rdata[CTRL_EN_BIT] = r_en;
        reg_idx(REG_STATUS): begin
          w_rdata[PEND_W-1:0]     = w_pend;
          w_rdata[STATUS_OVF_BIT] = w_ovf;
        end
        reg_idx(REG_TOTAL):  w_rdata = r_total;
`ifdef TICK_IRQ_TIMESTAMP_EN
        reg_idx(REG_TSTAMP): w_rdata = r_tstamp;
`endif
        default:             w_rdata = '0;
      endcase
    end
  end

  assign w_unused = ^{paddr[1:0], pwdata[30:2]};

  assign prdata  = w_rdata;
  assign pready  = 1'b1;
  assign pslverr = 1'b0;
  assign irq     = r_irq;

endmodule
